// File: rtl/apg_readback_packer.sv
// rtl/apg_readback_packer.sv - packs generator readback samples into 32-bit words and queues them in a FIFO
// Optional header word per shot: define APG_RB_HEADER_EN.
`timescale 1ns/1ps

module apg_readback_packer #(
    parameter int NUM_SIG  = 8,
    parameter int NUM_SAMP = 128,
    parameter int DEPTH    = 64
) (
    input  logic               axi_clk,
    input  logic               axi_resetn,
    input  logic               enable,
    input  logic               clear,
    input  logic [2:0]         apg_status,
    input  logic [31:0]        apg_n_samples,
    input  logic [NUM_SIG-1:0] apg_read_channel,
    output logic               apg_rdStrobe,
    output logic [31:0]        word_data,
    input  logic               word_rdStrobe,
    output logic [31:0]        word_count,
    output logic               busy,
    output logic               underflow
);

    localparam int         SPW      = 32 / NUM_SIG;
    localparam logic [5:0] SLOT_MAX = 6'(SPW - 1);
    localparam int         AW       = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_HDR, S_FETCH, S_WAIT, S_PUSH} state_t;

    state_t      state_q, state_d;
    logic [1:0]  sync1_q, sync2_q;
    logic        done_prev_q;
    logic [31:0] n_q, n_d, k_q, k_d, pack_q, pack_d;
    logic [5:0]  slot_q, slot_d;
    logic [31:0] n_eff;
    logic        done_s, done_rise;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          underflow_q;
    logic          full, pop_en, push_en;
    logic [31:0]   push_data;

    logic unused_triggered;
    assign unused_triggered = apg_status[2];

`ifdef APG_RB_HEADER_EN
    logic [15:0] shot_q, shot_d;
`endif

    assign done_s    = (sync2_q == 2'd2);
    assign done_rise = done_s && !done_prev_q;
    assign n_eff     = (apg_n_samples > 32'(NUM_SAMP)) ? 32'(NUM_SAMP) : apg_n_samples;
    assign full      = (cnt_q == DEPTH_C);
    assign pop_en    = word_rdStrobe && (cnt_q != '0);

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        k_d          = k_q;
        slot_d       = slot_q;
        pack_d       = pack_q;
        push_en      = 1'b0;
        push_data    = pack_q;
        apg_rdStrobe = 1'b0;
`ifdef APG_RB_HEADER_EN
        shot_d       = shot_q;
`endif
        case (state_q)
            S_IDLE: if (enable && done_rise) state_d = S_ARMED;
            S_ARMED: begin
                if (!done_s) begin
                    n_d    = n_eff;
                    k_d    = '0;
                    slot_d = '0;
                    pack_d = '0;
                    if (n_eff == '0)
                        state_d = S_IDLE;
                    else
`ifdef APG_RB_HEADER_EN
                        state_d = S_HDR;
`else
                        state_d = S_FETCH;
`endif
                end
            end
`ifdef APG_RB_HEADER_EN
            S_HDR: begin
                push_data = {shot_q, n_q[15:0]};
                if (!full) begin
                    push_en = 1'b1;
                    shot_d  = shot_q + 16'd1;
                    state_d = S_FETCH;
                end
            end
`endif
            S_FETCH: begin
                pack_d = pack_q | (32'(apg_read_channel) << (slot_q * NUM_SIG));
                k_d    = k_q + 32'd1;
                if (k_q + 32'd1 < n_q) apg_rdStrobe = 1'b1;
                if (slot_q == SLOT_MAX || k_q == n_q - 32'd1) begin
                    slot_d  = '0;
                    state_d = S_PUSH;
                end else begin
                    slot_d  = slot_q + 6'd1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: state_d = S_FETCH;
            S_PUSH: begin
                // Stalling here while full also holds off the next strobe.
                if (!full) begin
                    push_en = 1'b1;
                    pack_d  = '0;
                    state_d = (k_q < n_q) ? S_FETCH : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (clear || !enable) begin
            state_d      = S_IDLE;
            pack_d       = '0;
            push_en      = 1'b0;
            apg_rdStrobe = 1'b0;
`ifdef APG_RB_HEADER_EN
            shot_d       = shot_q;
`endif
        end
    end

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q     <= S_IDLE;
            sync1_q     <= '0;
            sync2_q     <= '0;
            done_prev_q <= 1'b0;
            n_q         <= '0;
            k_q         <= '0;
            slot_q      <= '0;
            pack_q      <= '0;
`ifdef APG_RB_HEADER_EN
            shot_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sync1_q     <= apg_status[1:0];
            sync2_q     <= sync1_q;
            done_prev_q <= done_s;
            n_q         <= n_d;
            k_q         <= k_d;
            slot_q      <= slot_d;
            pack_q      <= pack_d;
`ifdef APG_RB_HEADER_EN
            shot_q      <= shot_d;
`endif
        end
    end

    always_ff @(posedge axi_clk) begin
        if (push_en) mem_q[wr_q] <= push_data;
    end

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            underflow_q <= 1'b0;
        end else if (clear) begin
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            if (push_en) wr_q <= wr_q + 1'b1;
            if (pop_en)  rd_q <= rd_q + 1'b1;
            if (push_en && !pop_en)      cnt_q <= cnt_q + 1'b1;
            else if (!push_en && pop_en) cnt_q <= cnt_q - 1'b1;
            if (word_rdStrobe && cnt_q == '0) underflow_q <= 1'b1;
        end
    end

    // Gate the head so an empty FIFO (including right after reset) reads as 0.
    assign word_data  = (cnt_q == '0) ? 32'd0 : mem_q[rd_q];
    assign word_count = 32'(cnt_q);
    assign busy       = (state_q != S_IDLE);
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_apg_readback_packer.sv
// tb/tb_apg_readback_packer.sv - directed self-checking bench for apg_readback_packer
`timescale 1ns/1ps

module tb_apg_readback_packer;

    logic        axi_clk = 1'b0;
    logic        axi_resetn = 1'b0;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic [2:0]  apg_status = 3'd0;
    logic [31:0] apg_n_samples = 32'd0;
    logic [7:0]  apg_read_channel;
    logic        apg_rdStrobe;
    logic [31:0] word_data;
    logic        word_rdStrobe = 1'b0;
    logic [31:0] word_count;
    logic        busy;
    logic        underflow;

    int n_checks = 0;
    int n_errors = 0;
    int strobe_cnt = 0;
    int base = 0;
    logic [7:0] samp [32];

    apg_readback_packer #(.NUM_SIG(8), .NUM_SAMP(128), .DEPTH(2)) dut (
        .axi_clk(axi_clk), .axi_resetn(axi_resetn), .enable(enable), .clear(clear),
        .apg_status(apg_status), .apg_n_samples(apg_n_samples),
        .apg_read_channel(apg_read_channel), .apg_rdStrobe(apg_rdStrobe),
        .word_data(word_data), .word_rdStrobe(word_rdStrobe), .word_count(word_count),
        .busy(busy), .underflow(underflow)
    );

    always #5 axi_clk = ~axi_clk;

    // Generator model: readback pointer advances on each strobe.
    assign apg_read_channel = samp[(strobe_cnt - base) & 31];
    always @(posedge axi_clk) if (apg_rdStrobe) strobe_cnt <= strobe_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [7:0] start, input logic [7:0] step);
        for (int i = 0; i < 32; i++) samp[i] = 8'(start + step * i);
    endtask

    task automatic fire(input int n);
        @(negedge axi_clk);
        base = strobe_cnt;
        apg_n_samples = 32'(n);
        apg_status = 3'b010;
        repeat (4) @(negedge axi_clk);
        apg_status = 3'b000;
    endtask

    task automatic wait_idle(input string tag);
        int i = 0;
        while (busy && i < 300) begin
            @(negedge axi_clk);
            i++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic pop(input string tag, input logic [31:0] exp);
        @(negedge axi_clk);
        check(tag, word_data, exp);
        word_rdStrobe = 1'b1;
        @(negedge axi_clk);
        word_rdStrobe = 1'b0;
    endtask

    initial begin
        int i;
        repeat (3) @(negedge axi_clk);
        check("rst_count", word_count, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", word_data, 32'd0);
        axi_resetn = 1'b1;
        enable = 1'b1;
        @(negedge axi_clk);
        check("rst_strobe", 32'(apg_rdStrobe), 32'd0);

`ifdef APG_RB_HEADER_EN
        load(8'h11, 8'h11);
        fire(4);
        wait_idle("h1_idle");
        check("h1_count", word_count, 32'd2);
        pop("h1_hdr", 32'h0000_0004);
        pop("h1_data", 32'h4433_2211);
        load(8'hA1, 8'h01);
        fire(4);
        wait_idle("h2_idle");
        pop("h2_hdr", 32'h0001_0004);
        pop("h2_data", 32'hA4A3_A2A1);
`else
        // N=8, full words
        load(8'h11, 8'h11);
        fire(8);
        wait_idle("n8_idle");
        check("n8_count", word_count, 32'd2);
        check("n8_strobes", 32'(strobe_cnt - base), 32'd7);
        pop("n8_w0", 32'h4433_2211);
        pop("n8_w1", 32'h8877_6655);

        // N=5, zero-padded tail
        fire(5);
        wait_idle("n5_idle");
        check("n5_strobes", 32'(strobe_cnt - base), 32'd4);
        pop("n5_w0", 32'h4433_2211);
        pop("n5_w1", 32'h0000_0055);

        // Underflow, then clear
        @(negedge axi_clk);
        word_rdStrobe = 1'b1;
        @(negedge axi_clk);
        word_rdStrobe = 1'b0;
        check("uf_flag", 32'(underflow), 32'd1);
        check("uf_count", word_count, 32'd0);
        clear = 1'b1;
        @(negedge axi_clk);
        clear = 1'b0;
        check("clr_uf", 32'(underflow), 32'd0);

        // N=16 into a 2-deep FIFO: stall in PUSH
        load(8'h01, 8'h01);
        fire(16);
        repeat (60) @(negedge axi_clk);
        check("st_count", word_count, 32'd2);
        check("st_busy", 32'(busy), 32'd1);
        check("st_strobes", 32'(strobe_cnt - base), 32'd12);
        repeat (20) @(negedge axi_clk);
        check("st_hold", 32'(strobe_cnt - base), 32'd12);
        // Back-to-back pops: second coincides with the stalled push
        check("bb_w0", word_data, 32'h0403_0201);
        word_rdStrobe = 1'b1;
        @(negedge axi_clk);
        check("bb_w1", word_data, 32'h0807_0605);
        @(negedge axi_clk);
        word_rdStrobe = 1'b0;
        check("bb_count", word_count, 32'd1);
        check("bb_w2", word_data, 32'h0C0B_0A09);
        wait_idle("st_idle");
        check("st_count2", word_count, 32'd2);
        check("st_total", 32'(strobe_cnt - base), 32'd15);
        pop("st_w2", 32'h0C0B_0A09);
        pop("st_w3", 32'h100F_0E0D);

        // Abort with enable=0 after sample 3
        load(8'h11, 8'h11);
        fire(8);
        i = 0;
        while ((strobe_cnt - base) < 3 && i < 100) begin
            @(negedge axi_clk);
            i++;
        end
        check("ab_strobes", 32'(strobe_cnt - base), 32'd3);
        enable = 1'b0;
        @(negedge axi_clk);
        check("ab_busy", 32'(busy), 32'd0);
        repeat (10) @(negedge axi_clk);
        check("ab_hold", 32'(strobe_cnt - base), 32'd3);
        check("ab_count", word_count, 32'd0);
        enable = 1'b1;

        // Asynchronous reset mid-shot
        fire(8);
        i = 0;
        while (word_count != 32'd1 && i < 200) begin
            @(negedge axi_clk);
            i++;
        end
        check("ar_pre", word_count, 32'd1);
        #2;
        axi_resetn = 1'b0;
        #1;
        check("ar_count", word_count, 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_data", word_data, 32'd0);
        check("ar_strobe", 32'(apg_rdStrobe), 32'd0);
        check("ar_uf", 32'(underflow), 32'd0);
        @(negedge axi_clk);
        axi_resetn = 1'b1;
`endif
        repeat (2) @(negedge axi_clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
